fifo_drain_ctrl: RTL and testbench

//  Read-side controller for the LFSR-pointer synchronous FIFO. It pops a programmed

---
 rtl/fifo_lfsr_pkg.sv | 15 +
 rtl/fifo_drain_ctrl_if.sv | 21 ++
 rtl/lfsr_keystream.sv | 35 +++
 rtl/fifo_drain_ctrl.sv | 142 ++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_lfsr_pkg.sv
// rtl/fifo_lfsr_pkg.sv - shared types and constants for the FIFO drain controller
package fifo_lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback = q[0]^q[2]^q[3]^q[5]
  localparam logic [15:0] LFSR16_TAPS     = 16'h002D;
  localparam logic [15:0] KS_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// rtl/fifo_drain_ctrl_if.sv - FIFO read port plus valid/ready output stream of the drain controller
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/lfsr_keystream.sv
// rtl/lfsr_keystream.sv - Fibonacci LFSR keystream; load has priority over step
module lfsr_keystream
  import fifo_lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
  parameter logic [WIDTH-1:0] SEED  = KS_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (step) begin
      q_d = {^(q_q & TAPS), q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - drains burst_len words from a FIFO through a 2-entry skid buffer
// Optional output scrambling with an LFSR keystream when FIFO_DRAIN_SCRAMBLE_EN is defined.
module fifo_drain_ctrl
  import fifo_lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
`ifdef FIFO_DRAIN_SCRAMBLE_EN
  ,
  parameter logic [15:0] KS_SEED = KS_SEED_DEFAULT
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  fifo_drain_ctrl_if.master    bus
);
  drain_state_t          state_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic                  hs;
  logic                  rd_en;
  logic                  start_acc;
  logic [2:0]            occ_after;

  assign hs        = bus.m_valid & bus.m_ready;
  assign start_acc = start & (state_q == IDLE);
  // Occupancy the buffer would reach once the current read lands, net of this cycle's pop
  assign occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, hs};
  assign rd_en     = (state_q == RUN) & ~bus.fifo_empty & (issued_q < len_q) & (occ_after < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      issued_q <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q    <= burst_len;
            issued_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (rd_en) begin
            issued_q <= issued_q + CNT_WIDTH'(1);
          end
          if (issued_q == len_q) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (!inflight_q && occ_q == 2'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      case ({inflight_q, hs})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= bus.fifo_data;
          end else begin
            tail_q <= bus.fifo_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= bus.fifo_data;
          end else begin
            head_q <= tail_q;
            tail_q <= bus.fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_DRAIN_SCRAMBLE_EN
  logic [15:0] ks;

  lfsr_keystream #(
    .WIDTH (16),
    .TAPS  (LFSR16_TAPS),
    .SEED  (KS_SEED)
  ) u_keystream (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .step (hs),
    .q    (ks)
  );

  assign bus.m_data = head_q ^ ks[DATA_WIDTH-1:0];
`else
  assign bus.m_data = head_q;
`endif

  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.fifo_rd_en = rd_en;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl against a queue-based model
module tb_fifo_drain_ctrl;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic          m_ready = 1'b0;

  fifo_drain_ctrl_if #(.DATA_WIDTH(DW)) dif ();

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .bus       (dif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFO model: registered read, data valid the cycle after the strobe
  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  logic [DW-1:0] fdata = '0;
  assign dif.fifo_empty = (fcnt == 0);
  assign dif.fifo_data  = fdata;
  assign dif.m_ready    = m_ready;

  always @(posedge clk) begin
    if (!rst && dif.fifo_rd_en === 1'b1 && fq.size() > 0) begin
      fdata <= fq.pop_front();
      fcnt  <= fcnt - 1;
    end
  end

  int            cyc = 0;
  int            rd_cnt, valid_cnt, done_cnt, busy_cnt, done_cyc;
  int            hold_viol, rd_empty_viol;
  int            rd_cyc[$];
  int            hs_cyc[$];
  logic [DW-1:0] rx[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (dif.fifo_rd_en === 1'b1) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      if (dif.fifo_empty === 1'b1) rd_empty_viol++;
    end
    if (!rst) begin
      if (dif.m_valid === 1'b1) valid_cnt++;
      if (dif.m_valid === 1'b1 && dif.m_ready === 1'b1) begin
        rx.push_back(dif.m_data);
        hs_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      if (prev_stall && !(dif.m_valid === 1'b1 && dif.m_data === prev_data)) hold_viol++;
      prev_stall = (dif.m_valid === 1'b1) && (dif.m_ready !== 1'b1);
      prev_data  = dif.m_data;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  // Expected output word: the k-th word of a burst, scrambled by k keystream steps from the seed
  function automatic logic [DW-1:0] expw(input logic [DW-1:0] w, input int k);
`ifdef FIFO_DRAIN_SCRAMBLE_EN
    logic [15:0] s;
    logic        b;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) begin
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      s = {b, s[15:1]};
    end
    return w ^ s[DW-1:0];
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_cnt = 0; valid_cnt = 0; done_cnt = 0; busy_cnt = 0; done_cyc = 0;
    hold_viol = 0; rd_empty_viol = 0;
    rd_cyc.delete(); hs_cyc.delete(); rx.delete();
  endtask

  task automatic flush_src();
    fq.delete();
    fcnt = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    fcnt = fcnt + 1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    burst_len = CW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) tick();
  endtask

  task automatic check_rx(input string name, input logic [DW-1:0] words[$]);
    checks++;
    if (rx.size() != words.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, rx.size(), words.size());
    end else begin
      for (int i = 0; i < words.size(); i++) begin
        checks++;
        if (rx[i] !== expw(words[i], i)) begin
          errors++;
          $display("FAIL %s_word%0d: got %02h, expected %02h", name, i, rx[i], expw(words[i], i));
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] pre[$];
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({dif.fifo_rd_en, dif.m_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: rd_en,valid,busy,done = %b, expected 0000",
               {dif.fifo_rd_en, dif.m_valid, busy, done});
    end
    checks++;
    if (dif.m_data !== expw(8'h00, 0)) begin
      errors++;
      $display("FAIL reset_data: got %02h, expected %02h", dif.m_data, expw(8'h00, 0));
    end
    rst = 1'b0;
    tick();
    pre = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pre[i]) push_word(pre[i]);
    m_ready = 1'b0;
    do_start(4);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({dif.fifo_rd_en, dif.m_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: rd_en,valid,busy,done = %b, expected 0000",
               {dif.fifo_rd_en, dif.m_valid, busy, done});
    end
    rst = 1'b0;
    clear_logs();
    flush_src();
    repeat (5) tick();
    checks++;
    if (rd_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: rd_en pulses %0d busy %b, expected 0 and 0", rd_cnt, busy);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] words[$];
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    flush_src();
    foreach (words[i]) push_word(words[i]);
    m_ready = 1'b1;
    clear_logs();
    do_start(4);
    wait_done("basic", 40);
    check_rx("basic", words);
    checks++;
    if (rd_cnt != 4 || rd_cyc.size() != 4 || rd_cyc[3] - rd_cyc[0] != 3) begin
      errors++;
      $display("FAIL basic_rd_burst: %0d pulses, expected 4 on consecutive cycles", rd_cnt);
    end
    checks++;
    if (hs_cyc.size() != 4 || hs_cyc[3] - hs_cyc[0] != 3) begin
      errors++;
      $display("FAIL basic_hs_burst: %0d handshakes, expected 4 on consecutive cycles", hs_cyc.size());
    end
    checks++;
    if (done_cnt != 1 || hs_cyc.size() == 0 || done_cyc - hs_cyc[hs_cyc.size()-1] < 1 ||
        done_cyc - hs_cyc[hs_cyc.size()-1] > 2) begin
      errors++;
      $display("FAIL basic_done: %0d pulses at cycle %0d, expected 1 pulse shortly after last hs",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] words[$];
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    flush_src();
    foreach (words[i]) push_word(words[i]);
    m_ready = 1'b0;
    clear_logs();
    do_start(4);
    repeat (2) tick();
    do_start(9);
    repeat (3) tick();
    checks++;
    if (rd_cnt != 2) begin
      errors++;
      $display("FAIL stall_rd: %0d rd_en pulses before stall, expected 2", rd_cnt);
    end
    checks++;
    if (dif.m_valid !== 1'b1 || dif.m_data !== expw(8'h01, 0)) begin
      errors++;
      $display("FAIL stall_hold: valid %b data %02h, expected 1 %02h", dif.m_valid, dif.m_data,
               expw(8'h01, 0));
    end
    m_ready = 1'b1;
    wait_done("stall", 40);
    check_rx("stall", words);
    checks++;
    if (hold_viol != 0 || rd_cnt != 4) begin
      errors++;
      $display("FAIL stall_integrity: hold violations %0d rd_en %0d, expected 0 and 4", hold_viol, rd_cnt);
    end
  endtask

  task automatic test_empty_pause();
    logic [DW-1:0] words[$];
    words = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    flush_src();
    push_word(words[0]);
    push_word(words[1]);
    m_ready = 1'b1;
    clear_logs();
    do_start(4);
    repeat (5) tick();
    checks++;
    if (rd_cnt != 2 || busy !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL pause_state: rd_en %0d busy %b done %0d, expected 2 1 0", rd_cnt, busy, done_cnt);
    end
    push_word(words[2]);
    push_word(words[3]);
    wait_done("pause", 40);
    check_rx("pause", words);
    checks++;
    if (done_cnt != 1 || rd_empty_viol != 0) begin
      errors++;
      $display("FAIL pause_done: done %0d rd_on_empty %0d, expected 1 and 0", done_cnt, rd_empty_viol);
    end
  endtask

  task automatic test_zero_len();
    flush_src();
    push_word(8'h77);
    m_ready = 1'b1;
    clear_logs();
    do_start(0);
    repeat (8) tick();
    checks++;
    if (rd_cnt != 0 || valid_cnt != 0) begin
      errors++;
      $display("FAIL zero_len_io: rd_en %0d valid %0d, expected 0 and 0", rd_cnt, valid_cnt);
    end
    checks++;
    if (done_cnt != 1 || busy_cnt != 2) begin
      errors++;
      $display("FAIL zero_len_ctrl: done %0d busy cycles %0d, expected 1 and 2", done_cnt, busy_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [DW-1:0] pushed[$];
      logic [DW-1:0] expect_q[$];
      int len, pre, n;
      len = $urandom_range(1, 9);
      pre = $urandom_range(0, len + 2);
      flush_src();
      for (int i = 0; i < pre; i++) begin
        pushed.push_back(DW'($urandom));
        push_word(pushed[i]);
      end
      clear_logs();
      m_ready = ($urandom % 2) == 0;
      do_start(len);
      n = 0;
      while (done_cnt == 0 && n < 300) begin
        m_ready = ($urandom % 4) != 0;
        if (pushed.size() < len + 2 && ($urandom % 3) == 0) begin
          pushed.push_back(DW'($urandom));
          push_word(pushed[pushed.size()-1]);
        end
        tick();
        n++;
      end
      m_ready = 1'b1;
      checks++;
      if (done_cnt == 0) begin
        errors++;
        $display("FAIL rand%0d_timeout: no done, len %0d", it, len);
      end
      repeat (3) tick();
      for (int i = 0; i < len; i++) expect_q.push_back(pushed[i]);
      check_rx($sformatf("rand%0d", it), expect_q);
      checks++;
      if (rd_cnt != len || fq.size() != pushed.size() - len) begin
        errors++;
        $display("FAIL rand%0d_reads: rd_en %0d left %0d, expected %0d and %0d", it, rd_cnt,
                 fq.size(), len, pushed.size() - len);
      end
      checks++;
      if (hold_viol != 0 || rd_empty_viol != 0 || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_rules: hold %0d rd_on_empty %0d done %0d, expected 0 0 1", it,
                 hold_viol, rd_empty_viol, done_cnt);
      end
    end
  endtask

`ifdef FIFO_DRAIN_SCRAMBLE_EN
  task automatic test_scramble();
    logic [DW-1:0] words[$];
    words = '{8'h00, 8'h00};
    for (int r = 0; r < 2; r++) begin
      flush_src();
      foreach (words[i]) push_word(words[i]);
      m_ready = 1'b1;
      clear_logs();
      do_start(2);
      wait_done($sformatf("scramble%0d", r), 40);
      check_rx($sformatf("scramble%0d", r), words);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty_pause();
    test_zero_len();
    test_random();
`ifdef FIFO_DRAIN_SCRAMBLE_EN
    test_scramble();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
